// File: rtl/rf_rport_arb_if.sv
// Signal bundle between the regfile read-port-1 arbiter and its neighbours (id, debug, regfile, ctrl).
// The slave modport is the arbiter; the master modport is everything around it.
interface rf_rport_arb_if;
    logic        id_read_i;
    logic [4:0]  id_addr_i;
    logic [31:0] id_data_o;
    logic        dbg_req_i;
    logic [4:0]  dbg_addr_i;
    logic        dbg_ack_o;
    logic [31:0] dbg_data_o;
    logic        dbg_busy_o;
    logic        rf_re_o;
    logic [4:0]  rf_addr_o;
    logic [31:0] rf_data_i;
    logic        stall_req_o;

    modport slave (
        input  id_read_i, id_addr_i, dbg_req_i, dbg_addr_i, rf_data_i,
        output id_data_o, dbg_ack_o, dbg_data_o, dbg_busy_o, rf_re_o, rf_addr_o, stall_req_o
    );

    modport master (
        output id_read_i, id_addr_i, dbg_req_i, dbg_addr_i, rf_data_i,
        input  id_data_o, dbg_ack_o, dbg_data_o, dbg_busy_o, rf_re_o, rf_addr_o, stall_req_o
    );
endinterface

// File: rtl/rf_rport_arb.sv
// Regfile read port 1 arbiter: decode has priority, debug reads fill idle slots or force a one-cycle stall.
// Latency: decode path combinational; debug ack 2 cycles after request best case, STARVE_MAX+2 worst case.
// Backpressure: debug waits at most STARVE_MAX busy-decode cycles, then stalls the pipeline via ctrl for one cycle.
module rf_rport_arb #(
    parameter int unsigned STARVE_MAX = 8
) (
    input logic         clk,
    input logic         rst,
    rf_rport_arb_if.slave port
);

    localparam logic [3:0] WAIT_LAST = 4'(STARVE_MAX - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        STALL = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    logic [4:0]  dbg_addr_q;
    logic [3:0]  wait_cnt;
    logic [31:0] dbg_data_q;
    logic        dbg_ack_q;
    logic        dbg_own;

    // Debug takes the port in a free PEND slot or unconditionally in STALL.
    always_comb begin
        dbg_own = (state == STALL) || ((state == PEND) && !port.id_read_i);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            dbg_addr_q <= 5'd0;
            wait_cnt   <= 4'd0;
            dbg_data_q <= 32'd0;
            dbg_ack_q  <= 1'b0;
        end else begin
            dbg_ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (port.dbg_req_i) begin
                        dbg_addr_q <= port.dbg_addr_i;
                        wait_cnt   <= 4'd0;
                        state      <= PEND;
                    end
                end
                PEND: begin
                    if (!port.id_read_i) begin
                        dbg_data_q <= port.rf_data_i;
                        dbg_ack_q  <= 1'b1;
                        state      <= DONE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= STALL;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                STALL: begin
                    dbg_data_q <= port.rf_data_i;
                    dbg_ack_q  <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign port.dbg_ack_o   = dbg_ack_q;
    assign port.dbg_data_o  = dbg_data_q;
    assign port.dbg_busy_o  = (state != IDLE);
    assign port.stall_req_o = (state == STALL);

    // Decode sees zero data whenever debug holds the port; ctrl makes id re-read after a stall.
    assign port.rf_re_o   = dbg_own ? 1'b1 : port.id_read_i;
    assign port.rf_addr_o = dbg_own ? dbg_addr_q : (port.id_read_i ? port.id_addr_i : 5'd0);
    assign port.id_data_o = (!dbg_own && port.id_read_i) ? port.rf_data_i : 32'd0;

endmodule

// File: tb/tb_rf_rport_arb.sv
// Randomized scoreboard bench for rf_rport_arb: the driver predicts per-cycle port/handshake outputs
// from the arbitration rules, a negedge monitor pops and compares.
module tb_rf_rport_arb;
    localparam int SM = 8;

    typedef struct packed {
        logic        re;
        logic [4:0]  addr;
        logic [31:0] idata;
        logic        busy;
        logic        stall;
        logic        ack;
    } cyc_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rf_rport_arb_if port();

    rf_rport_arb #(.STARVE_MAX(SM)) dut (
        .clk  (clk),
        .rst  (rst),
        .port (port)
    );

    logic [31:0] regs [32];
    assign port.rf_data_i = regs[port.rf_addr_o];

    cyc_t        exp_q [$];
    logic [31:0] data_q [$];
    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Decode owns the port: regfile sees decode's request, decode gets regfile content.
    function automatic cyc_t dec(logic rd, logic [4:0] ia, logic busy, logic ack);
        cyc_t e;
        e.re    = rd;
        e.addr  = rd ? ia : 5'd0;
        e.idata = rd ? regs[ia] : 32'd0;
        e.busy  = busy;
        e.stall = 1'b0;
        e.ack   = ack;
        return e;
    endfunction

    function automatic cyc_t dbg(logic [4:0] a, logic stall);
        cyc_t e;
        e.re    = 1'b1;
        e.addr  = a;
        e.idata = 32'd0;
        e.busy  = 1'b1;
        e.stall = stall;
        e.ack   = 1'b0;
        return e;
    endfunction

    // Monitor: one expectation per driven cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cyc_t e;
            cyc_t a;
            e = exp_q.pop_front();
            a = {port.rf_re_o, port.rf_addr_o, port.id_data_o,
                 port.dbg_busy_o, port.stall_req_o, port.dbg_ack_o};
            chk("port_cycle", 64'(a), 64'(e));
            if (e.ack) begin
                if (data_q.size() == 0) begin
                    chk("dbg_data_queue_empty", 64'(1), 64'(0));
                end else begin
                    logic [31:0] d;
                    d = data_q.pop_front();
                    chk("dbg_data", 64'(port.dbg_data_o), 64'(d));
                end
            end
        end
    end

    task automatic drive(logic req, logic [4:0] da, logic rd, logic [4:0] ia, cyc_t e, logic push);
        @(posedge clk);
        #1;
        port.dbg_req_i  = req;
        port.dbg_addr_i = da;
        port.id_read_i  = rd;
        port.id_addr_i  = ia;
        if (push) exp_q.push_back(e);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            logic rd;
            logic [4:0] ia;
            rd = 1'($urandom);
            ia = 5'($urandom);
            drive(1'b0, 5'($urandom), rd, ia, dec(rd, ia, 1'b0, 1'b0), 1'b1);
        end
    endtask

    // mode 0: port free at once, 1: decode reads every cycle, 2: three busy cycles then free, 3: random
    task automatic do_txn(logic [4:0] addr, int mode, logic hold);
        int serve;
        logic rd;
        logic [4:0] ia;
        serve = SM;
        for (int j = 0; j < SM; j++) begin
            logic busy_slot;
            case (mode)
                0:       busy_slot = 1'b0;
                1:       busy_slot = 1'b1;
                2:       busy_slot = (j < 3);
                default: busy_slot = ($urandom_range(3) != 0);
            endcase
            if (!busy_slot) begin
                serve = j;
                break;
            end
        end
        data_q.push_back(regs[addr]);

        rd = 1'($urandom);
        ia = 5'($urandom);
        drive(1'b1, addr, rd, ia, dec(rd, ia, 1'b0, 1'b0), 1'b1);

        for (int j = 0; j <= serve; j++) begin
            logic req;
            ia  = 5'($urandom);
            req = hold ? 1'b1 : 1'($urandom);
            if (j < serve)
                drive(req, 5'($urandom), 1'b1, ia, dec(1'b1, ia, 1'b1, 1'b0), 1'b1);
            else if (serve < SM)
                drive(req, 5'($urandom), 1'b0, ia, dbg(addr, 1'b0), 1'b1);
            else
                drive(req, 5'($urandom), 1'($urandom), ia, dbg(addr, 1'b1), 1'b1);
        end

        rd = 1'($urandom);
        ia = 5'($urandom);
        drive(hold, 5'($urandom), rd, ia, dec(rd, ia, 1'b1, 1'b1), 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = 32'd0;
        regs[3] = 32'h1234_5678;
        regs[7] = 32'hDEAD_BEEF;

        // Reset holds the port with decode even while debug requests.
        port.dbg_req_i  = 1'b1;
        port.dbg_addr_i = 5'd9;
        port.id_read_i  = 1'b1;
        port.id_addr_i  = 5'd5;
        #22;
        chk("rst_ack",   64'(port.dbg_ack_o),   64'(0));
        chk("rst_stall", 64'(port.stall_req_o), 64'(0));
        chk("rst_re",    64'(port.rf_re_o),     64'(1));
        chk("rst_addr",  64'(port.rf_addr_o),   64'(5));
        chk("rst_busy",  64'(port.dbg_busy_o),  64'(0));
        chk("rst_data",  64'(port.dbg_data_o),  64'(0));
        chk("rst_idata", 64'(port.id_data_o),   64'(regs[5]));
        port.dbg_req_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        idle(2);
        do_txn(5'd3, 0, 1'b0);     // free port
        idle(2);
        do_txn(5'd7, 1, 1'b0);     // starvation -> forced stall
        idle(1);
        do_txn(5'd11, 2, 1'b0);    // gap after three busy cycles
        do_txn(5'd12, 0, 1'b1);    // held request: back-to-back acks every 3 cycles
        do_txn(5'd13, 0, 1'b1);
        do_txn(5'd14, 0, 1'b0);
        idle(2);

        // Reset asserted while in STALL.
        drive(1'b1, 5'd21, 1'b1, 5'd2, dec(1'b1, 5'd2, 1'b0, 1'b0), 1'b0);
        for (int j = 0; j < SM; j++)
            drive(1'b0, 5'd4, 1'b1, 5'd2, dec(1'b1, 5'd2, 1'b1, 1'b0), 1'b0);
        @(posedge clk);
        #1;
        chk("abort_stall_pre", 64'(port.stall_req_o), 64'(1));
        chk("abort_addr_pre",  64'(port.rf_addr_o),   64'(21));
        rst = 1'b0;
        #1;
        chk("abort_stall", 64'(port.stall_req_o), 64'(0));
        chk("abort_busy",  64'(port.dbg_busy_o),  64'(0));
        chk("abort_addr",  64'(port.rf_addr_o),   64'(2));
        repeat (2) @(posedge clk);
        #1;
        chk("abort_no_ack", 64'(port.dbg_ack_o), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        do_txn(5'd0, 0, 1'b0);     // address 0 reads zero
        idle(1);

        for (int t = 0; t < 40; t++) begin
            logic h;
            h = ($urandom_range(3) == 0);
            do_txn(5'($urandom), $urandom_range(3), h);
            if (!h) idle($urandom_range(2));
        end
        idle(3);
        @(negedge clk);
        #1;
        chk("exp_q_drained",  64'(exp_q.size()),  64'(0));
        chk("data_q_drained", 64'(data_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rf_rport_arb.md
# rf_rport_arb

Arbiter for regfile read port 1, shared between the decode stage and a debug/monitor read requester. Decode has priority every cycle; a debug read is served in a cycle where decode does not read port 1, or, after a bounded wait, by forcing a one-cycle pipeline stall through the ctrl block. The block sits between the id stage, the regfile and the ctrl (stall) block.

## Interface
- STARVE_MAX, 8, max PEND cycles a debug request waits before forcing a stall; legal range 1..15
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset; asserted when 0
- id_read_i  in  1  decode read enable for port 1 (id reg1_read_o)
- id_addr_i  in  5  decode read address (id reg1_addr_o)
- id_data_o  out  32  read data returned to decode (to id reg1_data_i)
- dbg_req_i  in  1  debug read request, level, sampled only in IDLE
- dbg_addr_i  in  5  debug register address, captured with request
- dbg_ack_o  out  1  one-cycle pulse: dbg_data_o valid
- dbg_data_o  out  32  captured debug read data, held until next capture
- dbg_busy_o  out  1  request accepted, not yet acked (state != IDLE)
- rf_re_o  out  1  regfile port 1 read enable
- rf_addr_o  out  5  regfile port 1 address
- rf_data_i  in  32  regfile port 1 data (combinational read)
- stall_req_o  out  1  stall request to ctrl, decoded from state only

## Operation
- States: IDLE, PEND, STALL, DONE. Registers: state, dbg_addr_q[4:0], wait_cnt[3:0], dbg_data_o, dbg_ack_o.
- IDLE: dbg_req_i=1 -> capture dbg_addr_i into dbg_addr_q, clear wait_cnt, go PEND.
- PEND, id_read_i=0: debug owns port; capture rf_data_i into dbg_data_o; go DONE.
- PEND, id_read_i=1, wait_cnt<STARVE_MAX-1: decode owns port; wait_cnt+1; stay.
- PEND, id_read_i=1, wait_cnt==STARVE_MAX-1: decode owns port this cycle; go STALL.
- STALL: stall_req_o=1; debug owns port unconditionally; capture rf_data_i; go DONE. Decode's read this cycle is discarded; ctrl holds id, which re-reads next cycle.
- DONE: dbg_ack_o=1 (registered); go IDLE. dbg_req_i ignored.
- Requester must drop dbg_req_i in the ack cycle; a request still high in IDLE is a new request.
- Port mux: debug owns -> rf_re_o=1, rf_addr_o=dbg_addr_q, id_data_o=0. Decode owns -> rf_re_o=id_read_i, rf_addr_o=id_read_i ? id_addr_i : 5'd0, id_data_o=id_read_i ? rf_data_i : 0.
- Address 0 is a normal debug read; data is whatever the regfile returns (0).
- wait_cnt never exceeds STARVE_MAX-1; no wrap.

## Timing
- Reset (rst=0, any time, any state): state=IDLE, dbg_addr_q=0, wait_cnt=0, dbg_data_o=0, dbg_ack_o=0; hence dbg_busy_o=0, stall_req_o=0, and port owned by decode. A pending request is dropped; requester must re-issue.
- Best case: req sampled at edge E0, capture at E1, dbg_ack_o high cycle after E1 (2 cycles req->ack).
- Worst case with decode reading every cycle: STARVE_MAX PEND cycles, 1 STALL, 1 DONE; ack STARVE_MAX+2 cycles after sample.
- stall_req_o high exactly one cycle per forced grant, never outside STALL; no input->stall_req_o path.
- Decode path is combinational (same cycle) whenever decode owns the port.
- Throughput: at most one debug read per 3 cycles (IDLE->PEND->DONE->IDLE).

## Test plan
- Reset: hold rst=0 with dbg_req_i=1, id_read_i=1, id_addr_i=5 -> dbg_ack_o=0, stall_req_o=0, rf_re_o=1, rf_addr_o=5, dbg_busy_o=0.
- Free port: id_read_i=0, dbg_req_i=1 one cycle, dbg_addr_i=3, reg3=0x1234_5678 -> rf_addr_o=3 next cycle, dbg_ack_o pulse 2 cycles after request, dbg_data_o=0x12345678, stall_req_o never 1.
- Starvation, STARVE_MAX=8: id_read_i=1 constantly, dbg_addr_i=7, reg7=0xDEADBEEF -> 8 PEND cycles with rf_addr_o=id_addr_i, then 1 cycle stall_req_o=1 with rf_addr_o=7, ack next cycle, dbg_data_o=0xDEADBEEF.
- Gap after wait: id_read_i=1 for 3 PEND cycles then 0 -> debug served in 4th PEND cycle, no stall, ack 5 cycles after request.
- Reset mid-operation: assert rst=0 in STALL -> stall_req_o and dbg_busy_o drop immediately; no ack; after release, request with dbg_addr_i=0 -> dbg_data_o=0, ack pulse.
- Held request: dbg_req_i held high 10 cycles with id idle -> acks every 3 cycles, each 1 cycle wide.
